ram_fifo_ctrl: RTL

- Upstream driver for the single-port synchronous RAM (ram1): turns it into a FIFO with valid/ready streams on both sides.
- Owns the RAM's addr, we and i_data ports; consumes o_data.
- Arbitrates the single port between writes and reads, one access per cycle.
- A 2-entry output buffer absorbs the 1-cycle RAM read latency, giving full throughput when no write contends.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_fifo_obuf.sv | 61 ++++++
 rtl/ram_fifo_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared constants for the RAM-backed FIFO controller: default widths,
// depth derivation and the write/read priority encoding.
package ram_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PRIO_WR = 1'b0;
    localparam logic PRIO_RD = 1'b1;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer that absorbs the one-cycle RAM read latency.
// Push and pop in the same cycle keep the occupancy unchanged.
module ram_fifo_obuf
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [1:0]            cnt_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  head_q;
    logic                  tail_q;
    logic [1:0]            cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (clear_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= data_i;
                tail_q        <= ~tail_q;
            end
            if (pop_i) begin
                head_q <= ~head_q;
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // The controller only issues a read when a slot is guaranteed free.
    assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_i && cnt_q == 2'd2));

    assign valid_o = (cnt_q != 2'd0);
    assign cnt_o   = cnt_q;
    assign data_o  = mem_q[head_q];

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-port synchronous RAM, one access per cycle.
// Optional synchronous flush input is enabled by defining RAM_FIFO_FLUSH_EN.
module ram_fifo_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef RAM_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int                DEPTH     = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  prio_q, prio_d;

    logic                  flush_w;
    logic                  pop;
    logic [1:0]            obuf_cnt;
    logic [2:0]            occ;
    logic                  rd_elig;
    logic                  wr_issue;
    logic                  rd_issue;
    logic                  contention;

`ifdef RAM_FIFO_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign count = count_q;

    assign pop = m_valid && m_ready;

    // Occupancy the buffer will have once the pending read lands and this pop retires.
    assign occ     = {1'b0, obuf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_elig = !empty && (occ < 3'd2);

    assign s_ready    = !rst && !flush_w && !full && !(rd_elig && prio_q == PRIO_RD);
    assign wr_issue   = s_valid && s_ready;
    assign rd_issue   = rd_elig && !wr_issue && !flush_w;
    assign contention = rd_elig && s_valid && !full && !flush_w;

    assign ram_we    = wr_issue;
    assign ram_addr  = wr_issue ? wr_ptr_q : rd_ptr_q;
    assign ram_wdata = s_data;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = rd_issue;
        prio_d     = prio_q;
        if (flush_w) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            prio_d     = PRIO_WR;
        end else begin
            if (wr_issue) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                count_d  = count_q + (ADDR_WIDTH + 1)'(1);
            end else if (rd_issue) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                count_d  = count_q - (ADDR_WIDTH + 1)'(1);
            end
            if (contention) begin
                prio_d = ~prio_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            prio_q     <= PRIO_WR;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            prio_q     <= prio_d;
        end
    end

    ram_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush_w),
        .push_i  (inflight_q && !flush_w),
        .pop_i   (pop && !flush_w),
        .data_i  (ram_rdata),
        .valid_o (m_valid),
        .cnt_o   (obuf_cnt),
        .data_o  (m_data)
    );

endmodule
